// File: rtl/pipeline_pkg.sv
// Shared definitions for the memory-access stage: funct3 size codes,
// writeback select encodings, FSM state type and alignment rule.
package pipeline_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] WB_SEL_ALU = 2'b00;
    localparam logic [1:0] WB_SEL_MEM = 2'b01;
    localparam logic [1:0] WB_SEL_PC4 = 2'b10;

    typedef enum logic {
        S_IDLE,
        S_ACCESS
    } mem_state_t;

    function automatic logic is_misaligned(input logic [1:0] offset, input logic [2:0] funct3);
        logic mis;
        mis = 1'b0;
        case (funct3)
            F3_LH, F3_LHU: mis = offset[0];
            F3_LW:         mis = (offset != 2'b00);
            default:       mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_store_align.sv
// Byte-lane alignment: store strobes/replicated data and load extraction
// with sign or zero extension, plus the misalignment flag.
module load_store_align
    import pipeline_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    input  logic [31:0] rs2,
    input  logic [31:0] rdata,
    output logic        misalign,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [31:0] shifted;

    always_comb begin
        misalign = is_misaligned(offset, funct3);
        shifted  = rdata >> {offset, 3'b000};

        wstrb = '0;
        wdata = rs2;
        case (funct3)
            F3_SB: begin
                wstrb = 4'b0001 << offset;
                wdata = {4{rs2[7:0]}};
            end
            F3_SH: begin
                wstrb = 4'b0011 << offset;
                wdata = {2{rs2[15:0]}};
            end
            F3_SW: begin
                wstrb = 4'hF;
                wdata = rs2;
            end
            default: begin
                wstrb = '0;
                wdata = rs2;
            end
        endcase

        case (funct3)
            F3_LB:   load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_LBU:  load_data = {24'h0, shifted[7:0]};
            F3_LHU:  load_data = {16'h0, shifted[15:0]};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/pipeline_mem_ctrl.sv
// Memory-access stage: EX/MEM register, branch resolution, request/ack
// data-memory port with timeout, and the MEM/WB register.
module pipeline_mem_ctrl
    import pipeline_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in_MEM,
    input  logic [31:0] ALU_in_MEM,
    input  logic [31:0] Rs2_in_MEM,
    input  logic        zero_in_MEM,
    input  logic [31:0] PC_imm_in_MEM,
    input  logic [31:0] PC4_in_MEM,
    input  logic        Branch_in_MEM,
    input  logic        Jump_in_MEM,
    input  logic        MemRead_in_MEM,
    input  logic        MemWrite_in_MEM,
    input  logic        RegWrite_in_MEM,
    input  logic [1:0]  MemtoReg_in_MEM,
    input  logic [2:0]  funct3_in_MEM,
    input  logic [4:0]  rd_in_MEM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall_out,
    output logic        PCSrc_out,
    output logic [31:0] PC_target_out,
    output logic        wb_valid,
    output logic        wb_RegWrite,
    output logic [1:0]  wb_MemtoReg,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_alu,
    output logic [31:0] wb_mem,
    output logic [31:0] wb_pc4,
    output logic        misalign_out,
    output logic        err_out
);

    localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic        em_valid, em_zero, em_Branch, em_Jump;
    logic        em_MemRead, em_MemWrite, em_RegWrite;
    logic [31:0] em_ALU, em_Rs2, em_PC_imm, em_PC4;
    logic [1:0]  em_MemtoReg;
    logic [2:0]  em_funct3;
    logic [4:0]  em_rd;

    mem_state_t  state, state_next;
    logic [CW-1:0] tmo_cnt;

    logic        em_misalign;
    logic [3:0]  lane_wstrb;
    logic [31:0] lane_wdata, load_data;
    logic        timeout, advance, capture_valid, capture_access;
    logic        mis_fault, abort;

    load_store_align u_align (
        .offset    (em_ALU[1:0]),
        .funct3    (em_funct3),
        .rs2       (em_Rs2),
        .rdata     (dmem_rdata),
        .misalign  (em_misalign),
        .wstrb     (lane_wstrb),
        .wdata     (lane_wdata),
        .load_data (load_data)
    );

    always_comb begin
        timeout        = (state == S_ACCESS) && (tmo_cnt == CW'(TIMEOUT - 1));
        stall_out      = (state == S_ACCESS) && !dmem_ack && !timeout;
        advance        = !stall_out;
        PCSrc_out      = em_valid & (em_Jump | (em_Branch & em_zero));
        PC_target_out  = em_PC_imm;
        capture_valid  = valid_in_MEM & ~PCSrc_out;
        // Decide ACCESS from the incoming op so the request rises the cycle after capture
        capture_access = capture_valid & (MemRead_in_MEM | MemWrite_in_MEM)
                       & ~is_misaligned(ALU_in_MEM[1:0], funct3_in_MEM);
        mis_fault      = em_valid & (em_MemRead | em_MemWrite) & em_misalign;
        abort          = (state == S_ACCESS) & ~dmem_ack;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (advance) state_next = capture_access ? S_ACCESS : S_IDLE;
    end

    always_comb begin
        dmem_req   = (state == S_ACCESS);
        dmem_we    = em_MemWrite;
        dmem_addr  = {em_ALU[31:2], 2'b00};
        dmem_wdata = lane_wdata;
        dmem_wstrb = em_MemWrite ? lane_wstrb : '0;
    end

    always_ff @(posedge clk) begin
        if (rst || advance)          tmo_cnt <= '0;
        else if (state == S_ACCESS)  tmo_cnt <= tmo_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            em_valid    <= 1'b0;
            em_ALU      <= '0;
            em_Rs2      <= '0;
            em_zero     <= 1'b0;
            em_PC_imm   <= '0;
            em_PC4      <= '0;
            em_Branch   <= 1'b0;
            em_Jump     <= 1'b0;
            em_MemRead  <= 1'b0;
            em_MemWrite <= 1'b0;
            em_RegWrite <= 1'b0;
            em_MemtoReg <= '0;
            em_funct3   <= '0;
            em_rd       <= '0;
        end else if (advance) begin
            em_valid    <= capture_valid;
            em_ALU      <= ALU_in_MEM;
            em_Rs2      <= Rs2_in_MEM;
            em_zero     <= zero_in_MEM;
            em_PC_imm   <= PC_imm_in_MEM;
            em_PC4      <= PC4_in_MEM;
            em_Branch   <= Branch_in_MEM;
            em_Jump     <= Jump_in_MEM;
            em_MemRead  <= MemRead_in_MEM;
            em_MemWrite <= MemWrite_in_MEM;
            em_RegWrite <= RegWrite_in_MEM;
            em_MemtoReg <= MemtoReg_in_MEM;
            em_funct3   <= funct3_in_MEM;
            em_rd       <= rd_in_MEM;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid     <= 1'b0;
            wb_RegWrite  <= 1'b0;
            wb_MemtoReg  <= '0;
            wb_rd        <= '0;
            wb_alu       <= '0;
            wb_mem       <= '0;
            wb_pc4       <= '0;
            misalign_out <= 1'b0;
            err_out      <= 1'b0;
        end else if (advance) begin
            wb_valid     <= em_valid;
            wb_RegWrite  <= em_valid & em_RegWrite & ~mis_fault & ~abort;
            wb_MemtoReg  <= em_MemtoReg;
            wb_rd        <= em_rd;
            wb_alu       <= em_ALU;
            wb_mem       <= ((state == S_ACCESS) && dmem_ack && em_MemRead) ? load_data : '0;
            wb_pc4       <= em_PC4;
            misalign_out <= mis_fault;
            err_out      <= abort;
        end
    end

endmodule

// File: tb/tb_pipeline_mem_ctrl.sv
// Scoreboard bench for pipeline_mem_ctrl: a program of EX results is fed in,
// a bench-side memory acknowledges after a per-op wait count.
module tb_pipeline_mem_ctrl;

    localparam int unsigned TMO = 4;

    typedef struct {
        logic [31:0] alu, rs2, pcimm, pc4, rdata;
        logic        zero, branch, jump, mr, mw, rw;
        logic [1:0]  m2r;
        logic [2:0]  f3;
        logic [4:0]  rd;
        int          waits;
    } ins_t;

    typedef struct {
        logic        rw, mis, err;
        logic [4:0]  rd;
        logic [1:0]  m2r;
        logic [31:0] alu, mem, pc4;
    } exp_t;

    logic        clk = 1'b0, rst;
    logic        valid_in_MEM, zero_in_MEM, Branch_in_MEM, Jump_in_MEM;
    logic        MemRead_in_MEM, MemWrite_in_MEM, RegWrite_in_MEM;
    logic [31:0] ALU_in_MEM, Rs2_in_MEM, PC_imm_in_MEM, PC4_in_MEM;
    logic [1:0]  MemtoReg_in_MEM;
    logic [2:0]  funct3_in_MEM;
    logic [4:0]  rd_in_MEM;
    logic        dmem_req, dmem_we, dmem_ack, stall_out, PCSrc_out;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, PC_target_out;
    logic [3:0]  dmem_wstrb;
    logic        wb_valid, wb_RegWrite, misalign_out, err_out;
    logic [1:0]  wb_MemtoReg;
    logic [4:0]  wb_rd;
    logic [31:0] wb_alu, wb_mem, wb_pc4;

    int checks = 0, errors = 0;

    ins_t prog[$];
    exp_t sbq[$];
    ins_t driven, em_tb;
    bit   driven_v = 0, em_v = 0;
    logic last_stall = 1'b0, last_pcsrc = 1'b0;
    int   reqcyc = 0;

    always #5 clk = ~clk;

    pipeline_mem_ctrl #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .valid_in_MEM(valid_in_MEM), .ALU_in_MEM(ALU_in_MEM),
        .Rs2_in_MEM(Rs2_in_MEM), .zero_in_MEM(zero_in_MEM), .PC_imm_in_MEM(PC_imm_in_MEM),
        .PC4_in_MEM(PC4_in_MEM), .Branch_in_MEM(Branch_in_MEM), .Jump_in_MEM(Jump_in_MEM),
        .MemRead_in_MEM(MemRead_in_MEM), .MemWrite_in_MEM(MemWrite_in_MEM),
        .RegWrite_in_MEM(RegWrite_in_MEM), .MemtoReg_in_MEM(MemtoReg_in_MEM),
        .funct3_in_MEM(funct3_in_MEM), .rd_in_MEM(rd_in_MEM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .stall_out(stall_out), .PCSrc_out(PCSrc_out),
        .PC_target_out(PC_target_out), .wb_valid(wb_valid), .wb_RegWrite(wb_RegWrite),
        .wb_MemtoReg(wb_MemtoReg), .wb_rd(wb_rd), .wb_alu(wb_alu), .wb_mem(wb_mem),
        .wb_pc4(wb_pc4), .misalign_out(misalign_out), .err_out(err_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic ins_t blank();
        ins_t i;
        i = '{default: '0};
        return i;
    endfunction

    function automatic ins_t ld(input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] rdata, input int waits, input logic [4:0] rd);
        ins_t i = blank();
        i.f3 = f3; i.alu = a; i.rdata = rdata; i.waits = waits; i.rd = rd;
        i.mr = 1'b1; i.rw = 1'b1; i.m2r = 2'b01; i.pc4 = a + 32'h1000;
        return i;
    endfunction

    function automatic ins_t st(input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] rs2, input int waits);
        ins_t i = blank();
        i.f3 = f3; i.alu = a; i.rs2 = rs2; i.waits = waits; i.mw = 1'b1;
        i.rdata = 32'hA5A5_5A5A; i.pc4 = a + 32'h2000; i.rd = 5'd9;
        return i;
    endfunction

    function automatic ins_t alu(input logic [31:0] v, input logic [4:0] rd);
        ins_t i = blank();
        i.alu = v; i.rd = rd; i.rw = 1'b1; i.pc4 = v ^ 32'h0000_F004;
        return i;
    endfunction

    function automatic ins_t ctl(input bit jump, input bit zero, input logic [31:0] tgt);
        ins_t i = blank();
        i.jump = jump; i.branch = !jump; i.zero = zero; i.pcimm = tgt;
        i.rw = jump; i.rd = 5'd1; i.m2r = jump ? 2'b10 : 2'b00;
        i.alu = 32'h0000_0077; i.pc4 = tgt + 32'h10;
        return i;
    endfunction

    function automatic bit is_mem(input ins_t i);
        return i.mr || i.mw;
    endfunction

    function automatic bit mis_of(input ins_t i);
        logic [1:0] o = i.alu[1:0];
        if (!is_mem(i)) return 0;
        if (i.f3 == 3'b001 || i.f3 == 3'b101) return o[0];
        if (i.f3 == 3'b010) return o != 2'b00;
        return 0;
    endfunction

    function automatic exp_t model(input ins_t i);
        exp_t e;
        logic [1:0]  o = i.alu[1:0];
        logic [7:0]  b = i.rdata[8*o +: 8];
        logic [15:0] h = i.rdata[16*o[1] +: 16];
        logic [31:0] v;
        case (i.f3)
            3'b000:  v = {{24{b[7]}}, b};
            3'b001:  v = {{16{h[15]}}, h};
            3'b100:  v = {24'h0, b};
            3'b101:  v = {16'h0, h};
            default: v = i.rdata;
        endcase
        e.mis = mis_of(i);
        e.err = is_mem(i) && !e.mis && (i.waits < 0 || i.waits >= int'(TMO));
        e.rw  = i.rw && !e.mis && !e.err;
        e.mem = (i.mr && !e.mis && !e.err) ? v : 32'h0;
        e.rd  = i.rd; e.m2r = i.m2r; e.alu = i.alu; e.pc4 = i.pc4;
        return e;
    endfunction

    task automatic drive(input ins_t i, input bit v);
        valid_in_MEM = v; ALU_in_MEM = i.alu; Rs2_in_MEM = i.rs2; zero_in_MEM = i.zero;
        PC_imm_in_MEM = i.pcimm; PC4_in_MEM = i.pc4; Branch_in_MEM = i.branch;
        Jump_in_MEM = i.jump; MemRead_in_MEM = i.mr; MemWrite_in_MEM = i.mw;
        RegWrite_in_MEM = i.rw; MemtoReg_in_MEM = i.m2r; funct3_in_MEM = i.f3;
        rd_in_MEM = i.rd;
    endtask

    task automatic step();
        exp_t e;
        bit   exp_req, exp_stall, exp_pcsrc;
        logic [3:0]  ew;
        logic [31:0] ed;
        @(posedge clk); #1;
        if (!last_stall) begin
            if (wb_valid) begin
                if (sbq.size() == 0) begin
                    check("wb_unexpected", wb_valid, 0);
                end else begin
                    e = sbq.pop_front();
                    check("wb_RegWrite", wb_RegWrite, e.rw);
                    check("wb_rd", wb_rd, e.rd);
                    check("wb_MemtoReg", wb_MemtoReg, e.m2r);
                    check("wb_alu", wb_alu, e.alu);
                    check("wb_mem", wb_mem, e.mem);
                    check("wb_pc4", wb_pc4, e.pc4);
                    check("misalign_out", misalign_out, e.mis);
                    check("err_out", err_out, e.err);
                end
            end else begin
                check("bubble_err", err_out, 0);
                check("bubble_misalign", misalign_out, 0);
            end
            em_v   = driven_v && !last_pcsrc;
            em_tb  = driven;
            reqcyc = 0;
            if (em_v) sbq.push_back(model(driven));
            if (driven_v) void'(prog.pop_front());
        end

        driven_v = prog.size() != 0;
        driven   = driven_v ? prog[0] : blank();
        drive(driven, driven_v);

        dmem_ack   = 1'b0;
        dmem_rdata = em_tb.rdata;
        exp_req    = em_v && is_mem(em_tb) && !mis_of(em_tb);
        check("dmem_req", dmem_req, exp_req);
        if (dmem_req) begin
            reqcyc++;
            case (em_tb.f3)
                3'b000:  begin ew = 4'b0001 << em_tb.alu[1:0]; ed = {4{em_tb.rs2[7:0]}}; end
                3'b001:  begin ew = 4'b0011 << em_tb.alu[1:0]; ed = {2{em_tb.rs2[15:0]}}; end
                default: begin ew = 4'hF; ed = em_tb.rs2; end
            endcase
            check("dmem_addr", dmem_addr, {em_tb.alu[31:2], 2'b00});
            check("dmem_we", dmem_we, em_tb.mw);
            check("dmem_wstrb", dmem_wstrb, em_tb.mw ? ew : 4'h0);
            if (em_tb.mw) check("dmem_wdata", dmem_wdata, ed);
            dmem_ack = (em_tb.waits >= 0) && (reqcyc == em_tb.waits + 1);
        end
        #1;
        exp_stall = exp_req && !dmem_ack && (reqcyc != int'(TMO));
        exp_pcsrc = em_v && (em_tb.jump || (em_tb.branch && em_tb.zero));
        check("stall_out", stall_out, exp_stall);
        check("PCSrc_out", PCSrc_out, exp_pcsrc);
        if (exp_pcsrc) check("PC_target_out", PC_target_out, em_tb.pcimm);
        last_stall = stall_out;
        last_pcsrc = PCSrc_out;
    endtask

    task automatic run_prog();
        int c = 0;
        while ((prog.size() != 0 || sbq.size() != 0 || driven_v) && c < 500) begin
            step();
            c++;
        end
        if (c >= 500) check("drain_budget", c, 0);
    endtask

    initial begin
        rst = 1'b1;
        drive(blank(), 0);
        dmem_ack = 1'b0;
        dmem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", dmem_req, 0);
        check("rst_stall", stall_out, 0);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_pcsrc", PCSrc_out, 0);
        rst = 1'b0;

        prog.push_back(st(3'b010, 32'h100, 32'hDEADBEEF, 2));
        prog.push_back(ld(3'b000, 32'h103, 32'h80FF_FF7F, 0, 5'd5));
        prog.push_back(ld(3'b100, 32'h103, 32'h80FF_FF7F, 1, 5'd6));
        prog.push_back(st(3'b001, 32'h101, 32'h0000_1234, 0));
        prog.push_back(ld(3'b010, 32'h106, 32'h1111_2222, 0, 5'd7));
        prog.push_back(alu(32'h55, 5'd3));
        prog.push_back(ctl(0, 1, 32'h40));
        prog.push_back(alu(32'h66, 5'd4));
        prog.push_back(alu(32'h67, 5'd8));
        prog.push_back(ld(3'b010, 32'h200, 32'hCAFE_F00D, -1, 5'd10));
        prog.push_back(alu(32'h68, 5'd11));
        prog.push_back(ld(3'b010, 32'h204, 32'h1234_5678, TMO - 1, 5'd12));
        prog.push_back(ld(3'b101, 32'h202, 32'h8001_1234, 0, 5'd13));
        prog.push_back(ld(3'b001, 32'h202, 32'h8001_1234, 0, 5'd14));
        for (int unsigned k = 0; k < 3; k++)
            prog.push_back(ld(3'b010, 32'h300 + 4 * k, 32'h0101_0101 * (k + 1), 0, 5'(16 + k)));
        prog.push_back(st(3'b000, 32'h003, 32'h0000_00AB, 0));
        prog.push_back(st(3'b001, 32'h002, 32'h0000_CDEF, 1));
        prog.push_back(ctl(1, 0, 32'h80));
        prog.push_back(ld(3'b010, 32'h400, 32'h9999_9999, 0, 5'd20));
        prog.push_back(ctl(0, 0, 32'hC0));
        prog.push_back(alu(32'h69, 5'd21));
        for (int unsigned k = 0; k < 6; k++) begin
            logic [2:0] f3s[5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
            logic [2:0] f3  = f3s[$urandom_range(4)];
            logic [31:0] a  = {$urandom_range(255), 2'b00} | ((f3 == 3'b010) ? 32'h0 :
                              (f3[0] ? 32'(2 * $urandom_range(1)) : 32'($urandom_range(3))));
            prog.push_back(ld(f3, a, $urandom, $urandom_range(2), 5'(24 + k)));
        end
        run_prog();

        prog.push_back(ld(3'b010, 32'h500, 32'h0, -1, 5'd7));
        step();
        step();
        step();
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_req", dmem_req, 0);
        check("midrst_stall", stall_out, 0);
        check("midrst_pcsrc", PCSrc_out, 0);
        check("midrst_wb_valid", wb_valid, 0);
        check("midrst_err", err_out, 0);
        check("midrst_addr", dmem_addr, 0);
        rst = 1'b0;
        sbq.delete();
        prog.delete();
        em_v = 0; driven_v = 0; last_stall = 1'b0; last_pcsrc = 1'b0;
        drive(blank(), 0);
        dmem_ack = 1'b1;
        @(posedge clk); #1;
        check("late_ack_wb_valid", wb_valid, 0);
        check("late_ack_req", dmem_req, 0);
        dmem_ack = 1'b0;

        prog.push_back(ld(3'b010, 32'h600, 32'h7654_3210, 0, 5'd2));
        prog.push_back(alu(32'hAA, 5'd3));
        run_prog();
        check("scoreboard_empty", sbq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_mem_ctrl.md
# pipeline_mem_ctrl

Memory-access stage of the five-stage pipelined core, consuming the execute stage's results (ALU result, store data, zero flag, branch target, PC+4). Holds the EX/MEM pipeline register, resolves branches and jumps, drives a request/acknowledge data-memory port with byte-lane alignment and load extension, and writes the MEM/WB register. Stalls the upstream pipeline while a memory access is outstanding.

## Interface
- TIMEOUT, 16: cycles in ACCESS without `dmem_ack` before the access is aborted; must be at least 2.
- clk  in  1  core clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- valid_in_MEM  in  1  EX result valid (0 = bubble)
- ALU_in_MEM  in  32  ALU result / memory byte address
- Rs2_in_MEM  in  32  store data
- zero_in_MEM  in  1  ALU zero flag
- PC_imm_in_MEM  in  32  branch/jump target
- PC4_in_MEM  in  32  PC+4
- Branch_in_MEM, Jump_in_MEM, MemRead_in_MEM, MemWrite_in_MEM, RegWrite_in_MEM  in  1 each  control
- MemtoReg_in_MEM  in  2  writeback select, passed through
- funct3_in_MEM  in  3  access size/sign
- rd_in_MEM  in  5  destination register
- dmem_req  out  1  access request
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word address (`ALU[31:2]`, 2'b00)
- dmem_wdata  out  32  lane-replicated store data
- dmem_wstrb  out  4  byte enables (0 for loads)
- dmem_ack  in  1  access complete; `dmem_rdata` valid this cycle
- dmem_rdata  in  32  read word
- stall_out  out  1  freeze PC, IF/ID, ID/EX, EX
- PCSrc_out  out  1  redirect to `PC_target_out`; also flushes IF/ID and ID/EX externally
- PC_target_out  out  32  registered `PC_imm`
- wb_valid, wb_RegWrite  out  1 each
- wb_MemtoReg  out  2
- wb_rd  out  5
- wb_alu, wb_mem, wb_pc4  out  32 each
- misalign_out, err_out  out  1 each  MEM/WB-registered exception flags

## Operation
- EX/MEM register (`em_*`) loads all inputs on every edge where `stall_out`=0. When `PCSrc_out`=1 it loads `valid`=0, squashing the wrong-path instruction in EX.
- `PCSrc_out` = `em_valid & (em_Jump | em_Branch & em_zero)`. Combinational from `em_*`, so it is never asserted during a stall.
- Misalignment: halfword (`funct3` 001/101) with `addr[0]`≠0, or word (010) with `addr[1:0]`≠0. No request is issued; MEM/WB gets `misalign_out`=1 and `wb_RegWrite`=0.
- Store lanes: sb gives `wstrb`=`1<<addr[1:0]` and `wdata`={4{Rs2[7:0]}}. sh gives `3<<addr[1:0]` and {2{Rs2[15:0]}}. sw gives 4'hF and Rs2.
- Load extract from `dmem_rdata` by `addr[1:0]`: lb/lh sign-extend, lbu/lhu zero-extend, lw passes the word.
- FSM states:
  - IDLE: the next state is ACCESS at any advancing edge that captures a valid, aligned mem op; otherwise the state stays IDLE.
  - ACCESS: `dmem_req`=1, and the request fields come from `em_*`.
    - On `dmem_ack` the MEM/WB register is written and the FSM takes the IDLE rule for the next captured op, so back-to-back accesses stay in ACCESS.
    - On timeout the access is aborted: MEM/WB gets `err_out`=1, `wb_mem`=0 and `wb_RegWrite`=0, then the FSM applies the same next-op rule.
- `stall_out` = (state==ACCESS) & ~`dmem_ack` & ~timeout.
- Non-memory ops pass into MEM/WB one cycle after capture with `wb_mem`=0.
- Timeout counter: cleared on entry to ACCESS and on each new access; increments in ACCESS; timeout when count == TIMEOUT-1.

## Timing
- Reset (also mid-ACCESS): FSM goes to IDLE, the counter clears, and all `em_*` and `wb_*` registers become 0. As a result every output is 0 after the edge, including `dmem_req`, `stall_out`, `PCSrc_out`, `misalign_out` and `err_out`. An outstanding ack arriving later is ignored.
- A mem op captured at edge k raises `dmem_req` in cycle k+1. Ack in cycle k+1 gives a 1-cycle stage latency, with `wb_*` valid after edge k+2. Each extra wait cycle adds one.
- While stalled, the MEM/WB register holds with `wb_valid` kept at its previous value, and the `dmem_*` outputs are stable.
- `err_out` and `misalign_out` are high for exactly one `wb_valid` cycle.
- Ack and timeout in the same cycle: ack wins and `err_out`=0.

## Structure
- Package `pipeline_pkg`: funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW), the FSM state enum and `MemtoReg` encodings.
- One combinational sub-module, `load_store_align`, produces the misalignment flag, wstrb, wdata and the extracted load data from addr, funct3, Rs2 and rdata.

## Test plan
- sw to 0x100 with Rs2=0xDEADBEEF, ack after 2 waits -> req for 3 cycles, wstrb=F, addr=0x100, `stall_out` for 2 cycles.
- lb at 0x103, rdata=0x80FF_FF7F -> `wb_mem`=0xFFFFFF80. Same access as lbu -> 0x00000080.
- sh at 0x101 -> no `dmem_req`, `misalign_out`=1, `wb_RegWrite`=0.
- Branch with zero=1, target 0x40 -> `PCSrc_out`=1 and `PC_target_out`=0x40 for one cycle, and the following instruction is captured with `valid`=0.
- TIMEOUT=4 with ack never given -> req for 4 cycles, `err_out`=1, then the next op proceeds. Assert `rst` in cycle 2 of a repeat -> all outputs 0 next cycle.
- Back-to-back lw/lw with ack each cycle -> req held high, one `wb_valid` per cycle, no stall.
